// File: rtl/mem_initiator_if.sv
// mem_initiator_if: client command/response handshake plus memory control bus.
// The shared mem_data bus is bidirectional and travels as a separate inout port.
interface mem_initiator_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 8
) ();
  // Client side
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;
  // Memory side
  logic                     mem_sel;
  logic                     mem_w_en;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_ready;

  // Initiator view
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_sel, mem_w_en, mem_addr
  );

  // Client / responder view
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_sel, mem_w_en, mem_addr
  );
endinterface

// File: rtl/mem_initiator.sv
// mem_initiator: accepts one read/write command at a time, runs it against the
// single-port latency memory and returns a one-cycle response pulse.
// Optional WAIT timeout abort is enabled by defining MEM_INITIATOR_TIMEOUT_EN.
module mem_initiator #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_initiator_if.master       bus,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     timeout_hit;
  logic                     sel;

  assign sel = (state_q == StIssue) || (state_q == StWait);

`ifdef MEM_INITIATOR_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // The TIMEOUT-th WAIT cycle without mem_ready aborts the command.
  assign timeout_hit = (state_q == StWait) && !bus.mem_ready &&
                       (cnt_q == CntW'(TIMEOUT - 1));

  // WAIT cycle counter and sticky error flag for the current command.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if (state_q == StWait && !bus.mem_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == StIdle && bus.req_valid) begin
      err_d = 1'b0;
    end else if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  // Timeout state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.rsp_err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign bus.rsp_err    = 1'b0;
`endif

  // Command FSM: capture on acceptance, one ISSUE cycle that ignores stale
  // mem_ready, WAIT for completion, then a single RESP cycle with select low.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = StIssue;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.mem_ready) begin
          state_d = StResp;
          rdata_d = we_q ? '0 : mem_data;
        end else if (timeout_hit) begin
          state_d = StResp;
          rdata_d = '0;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM and command registers; reset aborts any command without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_sel   = sel;
  assign bus.mem_w_en  = sel && we_q;
  assign bus.mem_addr  = addr_q;

  // Own the data bus only for the select window of a write; released otherwise.
  assign mem_data = (sel && we_q) ? wdata_q : 'z;

endmodule
